range_classifier: RTL
=====================

Name: range_classifier

Overview:
- Parametrised streaming range classifier: compares each accepted input value against NUM_BANDS programmable [lo, hi] bands.
- Reports the matching band, no-match and multi-match conditions under a selectable unique0 or priority decode mode.
- Sits between a value producer and its consumer, with valid/ready on both sides and one registered output slot.
- Keeps per-band hit statistics and a sticky overlap-error flag for software readback.

Parameters:
- WIDTH, 8, bit width of input value and band bounds (unsigned).
- NUM_BANDS, 4, number of bands (>=2).
- CNT_W, 16, width of each statistics counter.
- IDX_W, $clog2(NUM_BANDS), width of band index (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input value valid.
- in_ready  out  1  classifier can accept this cycle.
- in_value  in  WIDTH  value to classify.
- cfg_lo  in  NUM_BANDS*WIDTH  band lower bounds, band i at [i*WIDTH +: WIDTH], inclusive.
- cfg_hi  in  NUM_BANDS*WIDTH  band upper bounds, inclusive.
- cfg_mode  in  1  0 = UNIQUE0, 1 = PRIORITY.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_hit  out  1  at least one band matched.
- out_idx  out  IDX_W  winning band (lowest matching index); 0 when out_hit=0.
- out_multi  out  1  more than one band matched.
- err_overlap  out  1  sticky: multi-match seen in UNIQUE0 mode.
- err_clr  in  1  clears err_overlap.
- stat_hit  out  NUM_BANDS*CNT_W  per-band accepted-hit counters.
- stat_miss  out  CNT_W  no-match counter.
- stat_clr  in  1  clears all counters.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_hit=0, out_idx=0, out_multi=0, err_overlap=0, all stat counters 0. Reset mid-transfer drops the held result.
- in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready.
- Match vector: m[i] = (cfg_lo[i] <= in_value) && (in_value <= cfg_hi[i]). A band with lo > hi never matches. cfg_* and cfg_mode are sampled only on the accept cycle.
- Latency: 1 cycle. The result registers on the accept edge, and out_valid rises the next cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
- Output slot: out_* is held stable while out_valid && !out_ready. out_valid clears on an output handshake with no simultaneous accept. Simultaneous output handshake and accept loads the new result with out_valid staying 1.
- Decode: out_hit = |m. out_idx = lowest set index. out_multi = popcount(m) > 1.
  - UNIQUE0: multi-match sets err_overlap on the accept edge. No-match is legal.
  - PRIORITY: multi-match is legal; out_multi is still reported and err_overlap is unaffected.
- err_overlap: set has priority over err_clr in the same cycle.
- Counters, updated on the accept edge:
  - stat_hit[out_idx] increments on a hit.
  - stat_miss increments on a no-match.
  - All counters saturate at 2^CNT_W-1 with no wrap.
  - stat_clr has priority over increment; the counter value after the edge is 0.
- Internal 2-state FSM: EMPTY/FULL, tracking out_valid. EMPTY->FULL on accept. FULL->EMPTY on output handshake without accept. FULL->FULL otherwise.

Optional Feature:
- Macro RANGE_CLASSIFIER_STATS_EN.
- Defined: counters, stat_clr and the saturation logic are present as above.
- Undefined:
  - No counter flops are built.
  - stat_hit and stat_miss are tied to 0.
  - stat_clr is ignored.
  - Ports remain unchanged.

Decomposition:
- Package range_classifier_pkg holds:
  - typedef enum logic {MODE_UNIQUE0, MODE_PRIORITY} cls_mode_e.
  - typedef enum logic {ST_EMPTY, ST_FULL} cls_state_e.
  - Packed struct cls_result_t {hit, idx, multi}.
  - Function sat_inc(value, width).
- One combinational sub-module, range_match_decode: takes value, bounds and mode; produces the match vector, hit, idx and multi. The top module holds the registers, FSM and counters.

Test Plan:
- Common config: bands lo/hi = {0/9, 10/17, 18/29, 30/255}, UNIQUE0.
- Values 17, 18, 5, 200 with out_ready=1 -> out_idx=1, 2, 0, 3; all out_hit=1, out_multi=0; each result 1 cycle after accept.
- Band3 reprogrammed to 40/255, value 35 -> out_hit=0, out_idx=0, stat_miss=1.
- Overlap config band1=10/20, band2=18/29, value 19:
  - UNIQUE0 -> out_idx=1, out_multi=1, err_overlap=1.
  - Then err_clr with PRIORITY mode, value 19 -> out_idx=1, out_multi=1, err_overlap=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_* stable. Raising out_ready -> the next value is accepted the same cycle.
- CNT_W=2, value 5 sent 5 times -> stat_hit[0]=3 (saturated). stat_clr coinciding with a hit -> stat_hit[0]=0.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all counters 0, err_overlap=0.

Source files
------------

// File: rtl/range_classifier_pkg.sv
// Shared types and helpers for the range_classifier block.
// Used by range_match_decode and range_classifier.
package range_classifier_pkg;

  // Widest band index the result struct can carry (up to 256 bands).
  localparam int unsigned CLS_IDX_MAX_W = 8;

  typedef enum logic {
    MODE_UNIQUE0  = 1'b0,
    MODE_PRIORITY = 1'b1
  } cls_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cls_state_e;

  typedef struct packed {
    logic                     hit;
    logic [CLS_IDX_MAX_W-1:0] idx;
    logic                     multi;
  } cls_result_t;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    if (width >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (value >= max_v) begin
      return max_v;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/range_match_decode.sv
// Combinational band matcher: match vector, lowest matching index,
// multi-match flag and the UNIQUE0 overlap indication.
module range_match_decode
  import range_classifier_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_BANDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [WIDTH-1:0]           value,
  input  logic [NUM_BANDS*WIDTH-1:0] lo,
  input  logic [NUM_BANDS*WIDTH-1:0] hi,
  input  logic                       mode,
  output logic [NUM_BANDS-1:0]       match,
  output logic                       hit,
  output logic [IDX_W-1:0]           idx,
  output logic                       multi,
  output logic                       overlap
);

  // Per-band inclusive compare; a band with lo > hi can never match.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if ((lo[i*WIDTH +: WIDTH] <= value) && (value <= hi[i*WIDTH +: WIDTH])) begin
        match[i] = 1'b1;
      end else begin
        match[i] = 1'b0;
      end
    end
  end

  // Lowest matching band wins; any further match marks a multi-match.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    multi = 1'b0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (match[i] && !hit) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end else if (match[i]) begin
        multi = 1'b1;
      end else begin
        multi = multi;
      end
    end
  end

  assign overlap = multi && (cls_mode_e'(mode) == MODE_UNIQUE0);

endmodule

// File: rtl/range_classifier.sv
// Streaming range classifier with one registered output slot and sticky overlap flag.
// Per-band statistics counters are built only when RANGE_CLASSIFIER_STATS_EN is defined.
module range_classifier
  import range_classifier_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_BANDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_value,
  input  logic [NUM_BANDS*WIDTH-1:0] cfg_lo,
  input  logic [NUM_BANDS*WIDTH-1:0] cfg_hi,
  input  logic                       cfg_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hit,
  output logic [$clog2(NUM_BANDS)-1:0] out_idx,
  output logic                       out_multi,
  output logic                       err_overlap,
  input  logic                       err_clr,
  output logic [NUM_BANDS*CNT_W-1:0] stat_hit,
  output logic [CNT_W-1:0]           stat_miss,
  input  logic                       stat_clr
);

  localparam int IDX_W = $clog2(NUM_BANDS);

  if ((NUM_BANDS < 2) || (IDX_W > int'(CLS_IDX_MAX_W))) begin : g_bad_bands
    $error("range_classifier: NUM_BANDS must be in 2..256");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt
    $error("range_classifier: CNT_W must be in 1..32");
  end

  cls_state_e           state_r;
  cls_state_e           state_nxt_s;
  cls_result_t          result_r;
  cls_result_t          result_nxt_s;
  logic                 err_overlap_r;
  logic                 accept_s;
  logic [NUM_BANDS-1:0] band_match_unused_s;
  logic                 dec_hit_s;
  logic [IDX_W-1:0]     dec_idx_s;
  logic                 dec_multi_s;
  logic                 dec_overlap_s;

  range_match_decode #(
    .WIDTH     (WIDTH),
    .NUM_BANDS (NUM_BANDS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .value   (in_value),
    .lo      (cfg_lo),
    .hi      (cfg_hi),
    .mode    (cfg_mode),
    .match   (band_match_unused_s),
    .hit     (dec_hit_s),
    .idx     (dec_idx_s),
    .multi   (dec_multi_s),
    .overlap (dec_overlap_s)
  );

  assign out_valid = (state_r == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;

  // Slot occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Slot fills on accept and empties on a handshake that brings no replacement.
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = '0;
    result_nxt_s.hit   = dec_hit_s;
    result_nxt_s.idx   = CLS_IDX_MAX_W'(dec_idx_s);
    result_nxt_s.multi = dec_multi_s;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready && !accept_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Result slot: loads on accept, otherwise holds (stable under backpressure).
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
    end else if (accept_s) begin
      result_r <= result_nxt_s;
    end else begin
      result_r <= result_r;
    end
  end

  // Sticky overlap flag; a new overlap wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overlap_r <= 1'b0;
    end else if (accept_s && dec_overlap_s) begin
      err_overlap_r <= 1'b1;
    end else if (err_clr) begin
      err_overlap_r <= 1'b0;
    end else begin
      err_overlap_r <= err_overlap_r;
    end
  end

  assign out_hit     = result_r.hit;
  assign out_idx     = result_r.idx[IDX_W-1:0];
  assign out_multi   = result_r.multi;
  assign err_overlap = err_overlap_r;

  if (IDX_W < int'(CLS_IDX_MAX_W)) begin : g_idx_pad
    logic [int'(CLS_IDX_MAX_W)-IDX_W-1:0] idx_pad_unused_s;
    assign idx_pad_unused_s = result_r.idx[CLS_IDX_MAX_W-1:IDX_W];
  end

`ifdef RANGE_CLASSIFIER_STATS_EN
  logic [CNT_W-1:0] hit_cnt_r [NUM_BANDS];
  logic [CNT_W-1:0] miss_cnt_r;

  // Saturating hit/miss counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        hit_cnt_r[i] <= '0;
      end
      miss_cnt_r <= '0;
    end else if (accept_s) begin
      if (dec_hit_s) begin
        hit_cnt_r[dec_idx_s] <= CNT_W'(sat_inc(32'(hit_cnt_r[dec_idx_s]), CNT_W));
      end else begin
        miss_cnt_r <= CNT_W'(sat_inc(32'(miss_cnt_r), CNT_W));
      end
    end else begin
      miss_cnt_r <= miss_cnt_r;
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_stat_pack
    assign stat_hit[g*CNT_W +: CNT_W] = hit_cnt_r[g];
  end
  assign stat_miss = miss_cnt_r;
`else
  logic stat_clr_unused_s;
  assign stat_clr_unused_s = stat_clr;
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule
